// File: rtl/jvm_arm_translator.sv
// -----------------------------------------------------------------------------
// jvm_arm_translator
//
// Streaming translator from Java bytecode to ARM32 instruction words. Bytecode
// bytes arrive one per input handshake; each supported bytecode expands into a
// short fixed sequence of ARM words, one per output handshake. The Java operand
// stack is kept on the ARM stack (sp) and is accessed through the scratch
// registers TMP_REG (Ra) and TMP2_REG (Rb). Locals are word slots addressed off
// LV_BASE_REG.
//
// Handshake semantics (both sides): a transfer happens on a rising clock edge
// where valid and ready are both high. While out_valid is high the presented
// word does not change until it is taken. in_ready does not depend on in_valid
// and out_valid does not depend on out_ready.
//
// Ports:
//   clk         clock
//   reset       synchronous, active-high reset
//   in_valid    bytecode byte valid
//   in_byte     bytecode byte
//   in_ready    translator accepts a byte this cycle (low while emitting)
//   out_valid   instruction word valid
//   out_instr   ARM instruction word (zero when not valid)
//   out_ready   sink accepts the word
//   err         sticky flag: an unsupported opcode was seen
//   err_opcode  most recent unsupported opcode
//   bc_count    bytecodes fully emitted (nop counts on acceptance), wraps
//
// Debug: the FSM state is held in the internal signal 'state' (state_t).
// -----------------------------------------------------------------------------
module jvm_arm_translator #(
    parameter int TMP_REG     = 1,
    parameter int TMP2_REG    = 2,
    parameter int LV_BASE_REG = 3,
    parameter int LV_SHIFT    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out_instr,
    input  logic        out_ready,
    output logic        err,
    output logic [7:0]  err_opcode,
    output logic [15:0] bc_count
);

    typedef enum logic [1:0] {
        FETCH_OP = 2'd0,
        FETCH_A1 = 2'd1,
        FETCH_A2 = 2'd2,
        EMIT     = 2'd3
    } state_t;

    // Register numbers widened so they can be shifted into instruction fields.
    localparam logic [31:0] RA = 32'(TMP_REG);
    localparam logic [31:0] RB = 32'(TMP2_REG);
    localparam logic [31:0] RL = 32'(LV_BASE_REG);

    // Fixed words and base encodings with the register fields already merged.
    localparam logic [31:0] PUSH_W = 32'hE92D0000 | (32'd1 << TMP_REG);
    localparam logic [31:0] POP1_W = 32'hE8BD0000 | (32'd1 << TMP_REG);
    localparam logic [31:0] POP2_W = POP1_W | (32'd1 << TMP2_REG);
    localparam logic [31:0] MOVI_B = 32'hE3A00000 | (RA << 12);
    localparam logic [31:0] MVNI_B = 32'hE3E00000 | (RA << 12);
    localparam logic [31:0] MOVW_B = 32'hE3000000 | (RA << 12);
    localparam logic [31:0] MOVT_W = 32'hE34F0FFF | (RA << 12);
    localparam logic [31:0] LDR_B  = 32'hE5900000 | (RL << 16) | (RA << 12);
    localparam logic [31:0] STR_B  = 32'hE5800000 | (RL << 16) | (RA << 12);
    // After POP{Ra,Rb}: Ra = value2 (top), Rb = value1.
    localparam logic [31:0] ADD_W  = 32'hE0800000 | (RA << 16) | (RA << 12) | RB;
    // isub computes value1 - value2 = Rb - Ra.
    localparam logic [31:0] SUB_W  = 32'hE0400000 | (RB << 16) | (RA << 12) | RA;

    state_t      state;
    state_t      state_next;
    logic [7:0]  opcode;
    logic [7:0]  arg1;
    logic [7:0]  arg2;
    logic [1:0]  widx;

    // Per-opcode word sequence, selected by widx.
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [1:0]  last_idx;
    logic [31:0] word;
    logic        last_word;
    logic [7:0]  lv_idx;
    logic [11:0] lv_off;

    function automatic logic is_supported(input logic [7:0] op);
        return op inside {[8'h02:8'h08], 8'h10, 8'h11, 8'h15, [8'h1A:8'h1D],
                          8'h36, [8'h3B:8'h3E], 8'h60, 8'h64};
    endfunction

    function automatic logic has_operand(input logic [7:0] op);
        return op inside {8'h10, 8'h11, 8'h15, 8'h36};
    endfunction

    // ---------------------------------------------------------------------
    // Handshake outputs. Reset forces both sides idle in the reset cycle.
    // ---------------------------------------------------------------------
    always_comb begin
        in_ready  = !reset && (state != EMIT);
        out_valid = !reset && (state == EMIT);
        out_instr = out_valid ? word : 32'h0;
    end

    // ---------------------------------------------------------------------
    // Local-variable slot index and its byte offset.
    // ---------------------------------------------------------------------
    always_comb begin
        lv_idx = 8'h00;
        if (opcode == 8'h15 || opcode == 8'h36) begin
            lv_idx = arg1;
        end else if (opcode inside {[8'h1A:8'h1D]}) begin
            lv_idx = opcode - 8'h1A;
        end else if (opcode inside {[8'h3B:8'h3E]}) begin
            lv_idx = opcode - 8'h3B;
        end
        lv_off = {4'b0000, lv_idx} << LV_SHIFT;
    end

    // ---------------------------------------------------------------------
    // Word sequence for the latched bytecode. Only registered state feeds it.
    // ---------------------------------------------------------------------
    always_comb begin
        w0       = 32'h0;
        w1       = 32'h0;
        w2       = 32'h0;
        last_idx = 2'd0;
        if (opcode == 8'h02) begin
            w0       = MVNI_B;
            w1       = PUSH_W;
            last_idx = 2'd1;
        end else if (opcode inside {[8'h03:8'h08]}) begin
            w0       = MOVI_B | {24'h0, opcode - 8'h03};
            w1       = PUSH_W;
            last_idx = 2'd1;
        end else if (opcode == 8'h10) begin
            // Negative bytes are built as MVN of the complement.
            w0       = arg1[7] ? (MVNI_B | {24'h0, ~arg1}) : (MOVI_B | {24'h0, arg1});
            w1       = PUSH_W;
            last_idx = 2'd1;
        end else if (opcode == 8'h11) begin
            w0 = MOVW_B | {12'h0, arg1[7:4], 4'h0, arg1[3:0], arg2};
            if (arg1[7]) begin
                // Sign-extend the 16-bit value by filling the top half.
                w1       = MOVT_W;
                w2       = PUSH_W;
                last_idx = 2'd2;
            end else begin
                w1       = PUSH_W;
                last_idx = 2'd1;
            end
        end else if (opcode == 8'h15 || opcode inside {[8'h1A:8'h1D]}) begin
            w0       = LDR_B | {20'h0, lv_off};
            w1       = PUSH_W;
            last_idx = 2'd1;
        end else if (opcode == 8'h36 || opcode inside {[8'h3B:8'h3E]}) begin
            w0       = POP1_W;
            w1       = STR_B | {20'h0, lv_off};
            last_idx = 2'd1;
        end else if (opcode == 8'h60) begin
            w0       = POP2_W;
            w1       = ADD_W;
            w2       = PUSH_W;
            last_idx = 2'd2;
        end else if (opcode == 8'h64) begin
            w0       = POP2_W;
            w1       = SUB_W;
            w2       = PUSH_W;
            last_idx = 2'd2;
        end

        case (widx)
            2'd0:    word = w0;
            2'd1:    word = w1;
            default: word = w2;
        endcase
        last_word = (widx == last_idx);
    end

    // ---------------------------------------------------------------------
    // Next-state logic.
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            FETCH_OP: begin
                if (in_valid && in_byte != 8'h00 && is_supported(in_byte)) begin
                    state_next = has_operand(in_byte) ? FETCH_A1 : EMIT;
                end
            end
            FETCH_A1: begin
                if (in_valid) begin
                    state_next = (opcode == 8'h11) ? FETCH_A2 : EMIT;
                end
            end
            FETCH_A2: begin
                if (in_valid) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (out_ready && last_word) begin
                    state_next = FETCH_OP;
                end
            end
            default: state_next = FETCH_OP;
        endcase
    end

    // ---------------------------------------------------------------------
    // State and datapath registers.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH_OP;
            opcode     <= 8'h00;
            arg1       <= 8'h00;
            arg2       <= 8'h00;
            widx       <= 2'd0;
            err        <= 1'b0;
            err_opcode <= 8'h00;
            bc_count   <= 16'h0000;
        end else begin
            state <= state_next;
            case (state)
                FETCH_OP: begin
                    if (in_valid) begin
                        if (in_byte == 8'h00) begin
                            bc_count <= bc_count + 16'd1;
                        end else if (!is_supported(in_byte)) begin
                            err        <= 1'b1;
                            err_opcode <= in_byte;
                        end else begin
                            opcode <= in_byte;
                            widx   <= 2'd0;
                        end
                    end
                end
                FETCH_A1: begin
                    if (in_valid) begin
                        arg1 <= in_byte;
                    end
                end
                FETCH_A2: begin
                    if (in_valid) begin
                        arg2 <= in_byte;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (last_word) begin
                            widx     <= 2'd0;
                            bc_count <= bc_count + 16'd1;
                        end else begin
                            widx <= widx + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jvm_arm_translator.sv
// -----------------------------------------------------------------------------
// tb_jvm_arm_translator
//
// Scoreboard bench for jvm_arm_translator at default parameters. Expected ARM
// words are pushed into exp_q as each bytecode is driven; a monitor pops and
// compares on every output handshake, and also checks that a stalled word is
// held and that in_ready stays low while words are being emitted.
// -----------------------------------------------------------------------------
module tb_jvm_arm_translator;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_instr;
    logic        out_ready;
    logic        err;
    logic [7:0]  err_opcode;
    logic [15:0] bc_count;

    localparam logic [31:0] PUSH = 32'hE92D0002;
    localparam logic [31:0] POP1 = 32'hE8BD0002;
    localparam logic [31:0] POP2 = 32'hE8BD0006;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    bit          last_q[$];
    int          exp_bc = 0;
    bit          rand_ready = 0;
    bit          hold_pending = 0;
    logic [31:0] hold_word;
    logic [31:0] mon_w;
    bit          mon_l;
    logic [7:0]  op_tab [0:20];

    jvm_arm_translator dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_byte    (in_byte),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_instr  (out_instr),
        .out_ready  (out_ready),
        .err        (err),
        .err_opcode (err_opcode),
        .bc_count   (bc_count)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (reset) begin
            hold_pending = 0;
        end else begin
            if (hold_pending) begin
                check("hold_valid", out_valid, 1);
                check("hold_word", out_instr, hold_word);
                hold_pending = 0;
            end
            if (out_valid) begin
                check("in_ready_in_emit", in_ready, 0);
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", out_valid, 0);
                    end else begin
                        mon_w = exp_q.pop_front();
                        mon_l = last_q.pop_front();
                        check("word", out_instr, mon_w);
                        if (mon_l) exp_bc++;
                    end
                end else begin
                    hold_pending = 1;
                    hold_word    = out_instr;
                end
            end
        end
    end

    // Random backpressure when enabled.
    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_exp(input logic [31:0] w, input bit l);
        exp_q.push_back(w);
        last_q.push_back(l);
    endtask

    // Reference expansion of one bytecode at default register allocation.
    task automatic model_bc(input logic [7:0] op, input logic [7:0] a1, input logic [7:0] a2);
        logic [7:0]  idx;
        logic [7:0]  inv;
        if (op == 8'h00) begin
            exp_bc++;
        end else if (op == 8'h02) begin
            push_exp(32'hE3E01000, 0); push_exp(PUSH, 1);
        end else if (op >= 8'h03 && op <= 8'h08) begin
            push_exp(32'hE3A01000 + 32'(op - 8'h03), 0); push_exp(PUSH, 1);
        end else if (op == 8'h10) begin
            inv = ~a1;
            if (a1[7]) push_exp(32'hE3E01000 + 32'(inv), 0);
            else       push_exp(32'hE3A01000 + 32'(a1), 0);
            push_exp(PUSH, 1);
        end else if (op == 8'h11) begin
            push_exp(32'hE3001000 + (32'(a1[7:4]) << 16) + (32'(a1[3:0]) << 8) + 32'(a2), 0);
            if (a1[7]) push_exp(32'hE34F1FFF, 0);
            push_exp(PUSH, 1);
        end else if (op == 8'h15 || (op >= 8'h1A && op <= 8'h1D)) begin
            idx = (op == 8'h15) ? a1 : op - 8'h1A;
            push_exp(32'hE5931000 + 32'(idx) * 4, 0); push_exp(PUSH, 1);
        end else if (op == 8'h36 || (op >= 8'h3B && op <= 8'h3E)) begin
            idx = (op == 8'h36) ? a1 : op - 8'h3B;
            push_exp(POP1, 0); push_exp(32'hE5831000 + 32'(idx) * 4, 1);
        end else if (op == 8'h60) begin
            push_exp(POP2, 0); push_exp(32'hE0811002, 0); push_exp(PUSH, 1);
        end else if (op == 8'h64) begin
            push_exp(POP2, 0); push_exp(32'hE0421001, 0); push_exp(PUSH, 1);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_byte  = b;
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_byte  = 8'($urandom_range(0, 255));
    endtask

    task automatic do_bc(input logic [7:0] op, input logic [7:0] a1, input logic [7:0] a2);
        model_bc(op, a1, a2);
        send_byte(op);
        if (op == 8'h10 || op == 8'h11 || op == 8'h15 || op == 8'h36) send_byte(a1);
        if (op == 8'h11) send_byte(a2);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 0);
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        last_q.delete();
        exp_bc = 0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        op_tab = '{8'h00, 8'h02, 8'h03, 8'h05, 8'h08, 8'h10, 8'h10, 8'h11, 8'h11, 8'h15,
                   8'h1A, 8'h1D, 8'h36, 8'h3B, 8'h3E, 8'h60, 8'h64, 8'h64, 8'h60, 8'h1B, 8'h11};
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_byte   = 8'h00;
        out_ready = 1'b0;

        // Reset state
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_out_instr", out_instr, 0);
        check("rst_err", err, 0);
        check("rst_err_opcode", err_opcode, 0);
        check("rst_bc_count", bc_count, 0);
        check("idle_in_ready", in_ready, 1);

        // iconst_2, istore_1 with the sink always ready
        out_ready = 1'b1;
        model_bc(8'h05, 0, 0);
        send_byte(8'h05);
        @(negedge clk);
        check("first_word_latency", out_valid, 1);
        do_bc(8'h3C, 0, 0);
        wait_drain();
        check("bc_after_t1", bc_count, 16'(exp_bc));
        check("bc_t1_is_2", bc_count, 2);

        // bipush negative, iconst_m1
        do_bc(8'h10, 8'hFB, 0);
        do_bc(8'h02, 0, 0);
        // sipush with and without MOVT
        do_bc(8'h11, 8'h80, 8'h01);
        do_bc(8'h11, 8'h00, 8'h7F);
        wait_drain();
        check("bc_after_t3", bc_count, 16'(exp_bc));

        // iload 5 with out_ready 1,0,0,1, then isub
        do_bc(8'h15, 8'h05, 0);
        out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        @(posedge clk); #1; out_ready = 1'b0;
        @(posedge clk); #1; out_ready = 1'b1;
        do_bc(8'h64, 0, 0);
        wait_drain();
        check("bc_after_t4", bc_count, 16'(exp_bc));

        // Unsupported opcode, nop, iadd
        apply_reset();
        send_byte(8'hBA);
        @(negedge clk);
        check("err_set", err, 1);
        check("err_opcode_ba", err_opcode, 8'hBA);
        check("no_out_for_bad", out_valid, 0);
        do_bc(8'h00, 0, 0);
        do_bc(8'h60, 0, 0);
        wait_drain();
        check("bc_t5_is_2", bc_count, 2);
        check("err_sticky", err, 1);
        send_byte(8'hFF);
        @(negedge clk);
        check("err_opcode_ff", err_opcode, 8'hFF);

        // Reset while iadd's second word is stalled
        out_ready = 1'b0;
        do_bc(8'h60, 0, 0);
        out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        exp_q.delete();
        last_q.delete();
        exp_bc = 0;
        @(negedge clk);
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_bc_count", bc_count, 0);
        check("rst_mid_in_ready", in_ready, 1);
        check("rst_mid_err", err, 0);
        out_ready = 1'b1;
        do_bc(8'h03, 0, 0);
        wait_drain();
        check("bc_after_rst_mid", bc_count, 1);

        // Random stream with random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            do_bc(op_tab[$urandom_range(0, 20)], 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)));
        end
        wait_drain();
        rand_ready = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #2;
        check("bc_after_random", bc_count, 16'(exp_bc));
        check("queue_empty", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jvm_arm_translator.md
Name: jvm_arm_translator

Overview:
- Streaming Java-bytecode-to-ARM32 translator. Consumes one bytecode byte per valid/ready handshake and emits one 32-bit ARM instruction word per valid/ready handshake.
- Supersedes the fixed single-operand translator. Adds operand-carrying bytecodes (bipush, sipush, iload/istore with index), isub, iconst_m1 and backpressure on both sides.
- Register allocation is parametrised. Sits between the bytecode ROM reader and the instruction sink/logger.

Parameters:
- TMP_REG, 1, scratch register Ra (value / first pop).
- TMP2_REG, 2, second scratch register Rb; must be > TMP_REG.
- LV_BASE_REG, 3, local-variable frame base register.
- LV_SHIFT, 2, local index to byte-offset shift; legal range 0..4.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  bytecode byte valid
- in_byte  in  8  bytecode byte
- in_ready  out  1  translator accepts a byte this cycle
- out_valid  out  1  instr word valid
- out_instr  out  32  ARM instruction word
- out_ready  in  1  sink accepts the word
- err  out  1  sticky: unsupported opcode seen
- err_opcode  out  8  last unsupported opcode
- bc_count  out  16  bytecodes fully emitted; wraps at 0xFFFF->0

Behaviour:
- Reset: one clock, synchronous, active-high; applies in any state.
  - Reset values: state=FETCH_OP, in_ready=0 during reset, out_valid=0, out_instr=0, err=0, err_opcode=0, bc_count=0.
  - Reset mid-emission discards the pending bytecode; no further words from it.
- States:
  - FETCH_OP: in_ready=1. On handshake, latch opcode.
    - nop 0x00: stay in FETCH_OP; bc_count+1.
    - Unsupported opcode: err<=1, err_opcode<=byte, stay, no output.
    - Opcode with operands: go to FETCH_A1.
    - Otherwise: go to EMIT with widx=0.
  - FETCH_A1: in_ready=1. Latch arg1. Go to FETCH_A2 for sipush, else EMIT.
  - FETCH_A2: in_ready=1. Latch arg2. Go to EMIT.
  - EMIT: in_ready=0, out_valid=1. out_instr is driven only from registered opcode/args/widx.
    - Word and out_valid are held stable until out_ready.
    - On handshake, widx+1. After the last word, bc_count+1 and go to FETCH_OP (next cycle).
- Latency: the first word is valid the cycle after the final input byte handshake. With out_ready=1, one word per cycle. Words are never dropped or duplicated.
- Encodings (Ra=TMP_REG, Rb=TMP2_REG, Rl=LV_BASE_REG; hex at defaults):
  - PUSH{Ra} = E92D0000|1<<Ra (E92D0002)
  - POP{Ra} = E8BD0000|1<<Ra (E8BD0002)
  - POP{Ra,Rb} (E8BD0006); the ARM pop gives Ra=top=value2, Rb=value1.
  - MOVi = E3A00000|Ra<<12|imm8
  - MVNi = E3E00000|Ra<<12|imm8
  - MOVW = E3000000|imm[15:12]<<16|Ra<<12|imm[11:0]
  - MOVT#FFFF = E34F0FFF|Ra<<12
  - LDR = E5900000|Rl<<16|Ra<<12|off
  - STR = E5800000|Rl<<16|Ra<<12|off, where off = idx<<LV_SHIFT zero-extended to 12 bits
  - ADD Ra,Ra,Rb = E0800000|Ra<<16|Ra<<12|Rb (E0811002)
  - SUB Ra,Rb,Ra = E0400000|Rb<<16|Ra<<12|Ra (E0421001)
- Sequences:
  - iconst_m1 02: MVNi #0, PUSH.
  - iconst_0..5 03-08: MOVi #(op-3), PUSH.
  - bipush 10 v: if v[7]=0, MOVi #v; else MVNi #(~v). Then PUSH.
  - sipush 11 hi lo: MOVW #{hi,lo}; MOVT#FFFF only if hi[7]=1; then PUSH. This is 2 or 3 words.
  - iload 15 i: LDR idx=i, PUSH.
  - iload_0..3 1A-1D: LDR idx=op-1A, PUSH.
  - istore 36 i: POP{Ra}, STR idx=i.
  - istore_0..3 3B-3E: POP{Ra}, STR idx=op-3B.
  - iadd 60: POP{Ra,Rb}, ADD, PUSH.
  - isub 64: POP{Ra,Rb}, SUB, PUSH.
- err stays set until reset. A later unsupported opcode overwrites err_opcode.
- in_valid low in any FETCH state: hold state, no side effects.

Test Plan:
- Bytes 05,3C with out_ready=1 -> out_instr E3A01002, E92D0002, E8BD0002, E5831004; bc_count=2; each word one cycle apart within a bytecode.
- Bytes 10,FB then 02 -> E3E01004, E92D0002, E3E01000, E92D0002.
- Bytes 11,80,01 -> E3081001, E34F1FFF, E92D0002. Bytes 11,00,7F -> E300107F, E92D0002 (no MOVT).
- Bytes 15,05 then 64 with out_ready toggling 1,0,0,1 -> E5931014, E92D0002, E8BD0006, E0421001, E92D0002. out_instr held during stalls; in_ready=0 throughout EMIT.
- Bytes BA,00,60 -> err=1, err_opcode=BA, no output for BA/00, iadd emits E8BD0006, E0811002, E92D0002; bc_count=2.
- Reset asserted while the second word of iadd is pending -> next cycle out_valid=0, bc_count=0, in_ready=1. A following 03 emits E3A01000, E92D0002.
